// File: rtl/long_inst_scoreboard_pkg.sv
// Shared types and sizing for the long-instruction scoreboard.
// The commit-ID and register-address widths follow the core-wide macros.
`ifndef COMMIT_ID_WIDTH
`define COMMIT_ID_WIDTH 2
`endif
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif

package long_inst_scoreboard_pkg;

  localparam int SB_ID_W    = `COMMIT_ID_WIDTH;
  localparam int SB_RA_W    = `REG_ADDR_WIDTH;
  localparam int SB_ENTRIES = 1 << SB_ID_W;

  typedef struct packed {
    logic               valid;
    logic               we;
    logic [SB_RA_W-1:0] waddr;
  } sb_entry_t;

endpackage

// File: rtl/long_inst_scoreboard_sb_alloc_pe.sv
// Lowest-index free-entry priority encoder for scoreboard allocation.
// When every entry is valid the index defaults to zero.
module sb_alloc_pe #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     valid_i,
  output logic             free_any_o,
  output logic [IDX_W-1:0] free_idx_o
);

  // Walk from the top down so the lowest free index is the last one written.
  always_comb begin
    free_any_o = ~(&valid_i);
    free_idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!valid_i[i]) begin
        free_idx_o = IDX_W'(i);
      end else begin
        free_idx_o = free_idx_o;
      end
    end
  end

endmodule

// File: rtl/long_inst_scoreboard.sv
// Tracks in-flight long (MULDIV/LSU) instructions by commit ID and flags
// RAW/WAW hazards for the instruction currently in decode.
module long_inst_scoreboard
  import long_inst_scoreboard_pkg::*;
#(
  parameter int ID_W = SB_ID_W,
  parameter int RA_W = SB_RA_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid_i,
  input  logic            issue_we_i,
  input  logic [RA_W-1:0] issue_waddr_i,
  output logic            issue_ready_o,
  output logic [ID_W-1:0] issue_id_o,
  input  logic            commit_valid_i,
  input  logic [ID_W-1:0] commit_id_i,
  input  logic            flush_i,
  input  logic [RA_W-1:0] rs1_raddr_i,
  input  logic [RA_W-1:0] rs2_raddr_i,
  input  logic [RA_W-1:0] rd_raddr_i,
  output logic            rs1_hazard_o,
  output logic            rs2_hazard_o,
  output logic            rd_hazard_o,
  output logic            busy_o,
  output logic [ID_W:0]   outstanding_o,
  output logic            commit_err_o
);

  localparam int N = 1 << ID_W;

  sb_entry_t       tab_q [N];
  sb_entry_t       tab_d [N];
  logic            err_q;
  logic            err_d;
  logic [N-1:0]    valid_vec;
  logic            free_any;
  logic [ID_W-1:0] free_idx;
  logic            issue_fire;
  logic            commit_fire;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      valid_vec[i] = tab_q[i].valid;
    end
  end

  sb_alloc_pe #(
    .N     (N),
    .IDX_W (ID_W)
  ) u_alloc_pe (
    .valid_i    (valid_vec),
    .free_any_o (free_any),
    .free_idx_o (free_idx)
  );

  assign issue_ready_o = free_any;
  assign issue_id_o    = free_idx;
  assign issue_fire    = issue_valid_i && free_any && !flush_i;
  assign commit_fire   = commit_valid_i && !flush_i;

  // The allocated index comes from registered state, so a slot freed by this
  // cycle's commit is never handed out until the next cycle.
  always_comb begin
    tab_d = tab_q;
    err_d = err_q;
    if (flush_i) begin
      for (int i = 0; i < N; i++) begin
        tab_d[i].valid = 1'b0;
      end
    end else begin
      if (commit_fire) begin
        if (tab_q[commit_id_i].valid) begin
          tab_d[commit_id_i].valid = 1'b0;
        end else begin
          err_d = 1'b1;
        end
      end else begin
        err_d = err_q;
      end
      if (issue_fire) begin
        tab_d[free_idx].valid = 1'b1;
        tab_d[free_idx].we    = issue_we_i;
        tab_d[free_idx].waddr = issue_waddr_i;
      end else begin
        tab_d[free_idx] = tab_d[free_idx];
      end
    end
  end

  // Only valid bits and the error flag are reset; we/waddr are don't-care while invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        tab_q[i].valid <= 1'b0;
      end
      err_q <= 1'b0;
    end else begin
      tab_q <= tab_d;
      err_q <= err_d;
    end
  end

  // The completing entry is excluded: the register file bypasses its write.
  always_comb begin
    rs1_hazard_o = 1'b0;
    rs2_hazard_o = 1'b0;
    rd_hazard_o  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (tab_q[i].valid && tab_q[i].we &&
          !(commit_valid_i && (commit_id_i == ID_W'(i)))) begin
        if ((rs1_raddr_i != '0) && (tab_q[i].waddr == rs1_raddr_i)) rs1_hazard_o = 1'b1;
        else rs1_hazard_o = rs1_hazard_o;
        if ((rs2_raddr_i != '0) && (tab_q[i].waddr == rs2_raddr_i)) rs2_hazard_o = 1'b1;
        else rs2_hazard_o = rs2_hazard_o;
        if ((rd_raddr_i != '0) && (tab_q[i].waddr == rd_raddr_i)) rd_hazard_o = 1'b1;
        else rd_hazard_o = rd_hazard_o;
      end else begin
        rs1_hazard_o = rs1_hazard_o;
      end
    end
  end

  always_comb begin
    outstanding_o = '0;
    for (int i = 0; i < N; i++) begin
      outstanding_o = outstanding_o + (ID_W + 1)'(valid_vec[i]);
    end
  end

  assign busy_o       = (outstanding_o != '0);
  assign commit_err_o = err_q;

endmodule

// File: tb/tb_long_inst_scoreboard.sv
// Bench for long_inst_scoreboard: a hand-written vector table for the directed
// corner cases, then a random phase checked against a small reference model.
module tb_long_inst_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       issue_valid_i, issue_we_i;
  logic [4:0] issue_waddr_i;
  logic       issue_ready_o;
  logic [1:0] issue_id_o;
  logic       commit_valid_i;
  logic [1:0] commit_id_i;
  logic       flush_i;
  logic [4:0] rs1_raddr_i, rs2_raddr_i, rd_raddr_i;
  logic       rs1_hazard_o, rs2_hazard_o, rd_hazard_o;
  logic       busy_o;
  logic [2:0] outstanding_o;
  logic       commit_err_o;

  int checks = 0;
  int errors = 0;

  long_inst_scoreboard dut (
    .clk(clk), .rst(rst),
    .issue_valid_i(issue_valid_i), .issue_we_i(issue_we_i), .issue_waddr_i(issue_waddr_i),
    .issue_ready_o(issue_ready_o), .issue_id_o(issue_id_o),
    .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .flush_i(flush_i),
    .rs1_raddr_i(rs1_raddr_i), .rs2_raddr_i(rs2_raddr_i), .rd_raddr_i(rd_raddr_i),
    .rs1_hazard_o(rs1_hazard_o), .rs2_hazard_o(rs2_hazard_o), .rd_hazard_o(rd_hazard_o),
    .busy_o(busy_o), .outstanding_o(outstanding_o), .commit_err_o(commit_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, iv, we;
    logic [4:0] wa;
    logic       cv;
    logic [1:0] cid;
    logic       fl;
    logic [4:0] r1, r2, rd;
    logic       e_rdy;
    logic [1:0] e_id;
    logic       e_h1, e_h2, e_hd;
    logic [2:0] e_out;
    logic       e_err;
    logic       chk;
  } vec_t;

  typedef struct {
    logic       rdy;
    logic [1:0] id;
    logic       h1, h2, hd;
    logic [2:0] out;
    logic       busy;
    logic       err;
  } exp_t;

  vec_t tbl[$];
  exp_t sb_q[$];

  // reference model state
  logic       m_v[4];
  logic       m_we[4];
  logic [4:0] m_wa[4];
  logic       m_err;

  task automatic row(input logic rst_v, iv, we, input logic [4:0] wa, input logic cv,
                     input logic [1:0] cid, input logic fl, input logic [4:0] r1, r2, rd,
                     input logic e_rdy, input logic [1:0] e_id, input logic e_h1, e_h2, e_hd,
                     input logic [2:0] e_out, input logic e_err, input logic chk);
    vec_t v;
    v.rst = rst_v; v.iv = iv; v.we = we; v.wa = wa; v.cv = cv; v.cid = cid; v.fl = fl;
    v.r1 = r1; v.r2 = r2; v.rd = rd; v.e_rdy = e_rdy; v.e_id = e_id;
    v.e_h1 = e_h1; v.e_h2 = e_h2; v.e_hd = e_hd; v.e_out = e_out; v.e_err = e_err; v.chk = chk;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic rst_v, iv, we, input logic [4:0] wa, input logic cv,
                       input logic [1:0] cid, input logic fl, input logic [4:0] r1, r2, rd);
    rst = rst_v; issue_valid_i = iv; issue_we_i = we; issue_waddr_i = wa;
    commit_valid_i = cv; commit_id_i = cid; flush_i = fl;
    rs1_raddr_i = r1; rs2_raddr_i = r2; rd_raddr_i = rd;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    exp_t e;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty actual 0 expected 1");
    end else begin
      e = sb_q.pop_front();
      chk("issue_ready", {7'd0, issue_ready_o}, {7'd0, e.rdy});
      chk("issue_id",    {6'd0, issue_id_o},    {6'd0, e.id});
      chk("rs1_hazard",  {7'd0, rs1_hazard_o},  {7'd0, e.h1});
      chk("rs2_hazard",  {7'd0, rs2_hazard_o},  {7'd0, e.h2});
      chk("rd_hazard",   {7'd0, rd_hazard_o},   {7'd0, e.hd});
      chk("outstanding", {5'd0, outstanding_o}, {5'd0, e.out});
      chk("busy",        {7'd0, busy_o},        {7'd0, e.busy});
      chk("commit_err",  {7'd0, commit_err_o},  {7'd0, e.err});
    end
  endtask

  function automatic logic model_haz(input logic [4:0] a, input logic cv, input logic [1:0] cid);
    logic h;
    h = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (a != 5'd0 && m_v[i] && m_we[i] && m_wa[i] == a && !(cv && cid == 2'(i))) h = 1'b1;
    end
    return h;
  endfunction

  initial begin
    exp_t e;
    logic rdy_m;
    logic [1:0] id_m;
    logic [2:0] cnt;
    logic r_rst, r_iv, r_we, r_cv, r_fl;
    logic [4:0] r_wa, r_1, r_2, r_d;
    logic [1:0] r_cid;

    drive(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0, 5'd0, 5'd0, 5'd0);

    //   rst   iv    we    wa     cv    cid   fl    r1     r2     rd   | rdy   id    h1    h2    hd    out   err   chk
    row(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0, 5'd0, 5'd0, 5'd0,  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    row(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0, 5'd0, 5'd0, 5'd0,  1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    row(1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 2'd0, 1'b0, 5'd0, 5'd0, 5'd0,  1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    row(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0, 5'd5, 5'd0, 5'd0,  1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b1);
    row(1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 2'd0, 1'b0, 5'd0, 5'd0, 5'd5,  1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b1);
    row(1'b0, 1'b1, 1'b1, 5'd3, 1'b0, 2'd0, 1'b0, 5'd0, 5'd7, 5'd0,  1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 1'b1);
    row(1'b0, 1'b1, 1'b1, 5'd0, 1'b1, 2'd1, 1'b0, 5'd0, 5'd7, 5'd0,  1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b1);
    row(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0, 5'd0, 5'd7, 5'd3,  1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b1);
    row(1'b0, 1'b1, 1'b1, 5'd9, 1'b1, 2'd0, 1'b1, 5'd5, 5'd0, 5'd0,  1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b1);
    row(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0, 5'd0, 5'd0, 5'd0,  1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    row(1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 2'd3, 1'b0, 5'd0, 5'd0, 5'd0,  1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    row(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0, 5'd0, 5'd0, 5'd0,  1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1);
    row(1'b0, 1'b1, 1'b1, 5'd1, 1'b0, 2'd0, 1'b0, 5'd0, 5'd0, 5'd0,  1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1);
    row(1'b0, 1'b1, 1'b1, 5'd2, 1'b0, 2'd0, 1'b0, 5'd0, 5'd0, 5'd0,  1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1);
    row(1'b0, 1'b1, 1'b1, 5'd3, 1'b0, 2'd0, 1'b0, 5'd0, 5'd0, 5'd0,  1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1);
    row(1'b0, 1'b1, 1'b1, 5'd4, 1'b0, 2'd0, 1'b0, 5'd0, 5'd0, 5'd0,  1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1);
    row(1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 2'd0, 1'b0, 5'd4, 5'd0, 5'd0,  1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1);
    row(1'b0, 1'b1, 1'b1, 5'd9, 1'b1, 2'd2, 1'b0, 5'd9, 5'd3, 5'd2,  1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 1'b1);
    row(1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 2'd0, 1'b0, 5'd0, 5'd0, 5'd0,  1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1);
    row(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0, 5'd9, 5'd0, 5'd0,  1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1);
    row(1'b1, 1'b1, 1'b1, 5'd8, 1'b1, 2'd0, 1'b1, 5'd0, 5'd0, 5'd0,  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1);
    row(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0, 5'd0, 5'd0, 5'd0,  1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    row(1'b0, 1'b1, 1'b0, 5'd6, 1'b0, 2'd0, 1'b0, 5'd0, 5'd0, 5'd0,  1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    row(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0, 5'd6, 5'd0, 5'd6,  1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b1);

    for (int k = 0; k < tbl.size(); k++) begin
      @(posedge clk); #1;
      drive(tbl[k].rst, tbl[k].iv, tbl[k].we, tbl[k].wa, tbl[k].cv, tbl[k].cid, tbl[k].fl,
            tbl[k].r1, tbl[k].r2, tbl[k].rd);
      if (tbl[k].chk) begin
        e.rdy = tbl[k].e_rdy; e.id = tbl[k].e_id; e.h1 = tbl[k].e_h1; e.h2 = tbl[k].e_h2;
        e.hd = tbl[k].e_hd; e.out = tbl[k].e_out; e.busy = (tbl[k].e_out != 3'd0);
        e.err = tbl[k].e_err;
        sb_q.push_back(e);
      end
      @(negedge clk);
      if (tbl[k].chk) compare_outputs();
    end

    // Random phase: the first cycle is a reset so the model starts in sync.
    for (int i = 0; i < 4; i++) begin
      m_v[i] = 1'b0; m_we[i] = 1'b0; m_wa[i] = 5'd0;
    end
    m_err = 1'b0;
    for (int c = 0; c < 400; c++) begin
      r_rst = (c == 0) || ($urandom_range(0, 60) == 0);
      r_iv  = ($urandom_range(0, 2) != 0);
      r_we  = ($urandom_range(0, 3) != 0);
      r_wa  = 5'($urandom_range(0, 7));
      r_cv  = ($urandom_range(0, 2) == 0);
      r_cid = 2'($urandom_range(0, 3));
      r_fl  = ($urandom_range(0, 30) == 0);
      r_1   = 5'($urandom_range(0, 7));
      r_2   = 5'($urandom_range(0, 7));
      r_d   = 5'($urandom_range(0, 7));
      @(posedge clk); #1;
      drive(r_rst, r_iv, r_we, r_wa, r_cv, r_cid, r_fl, r_1, r_2, r_d);

      rdy_m = !(m_v[0] && m_v[1] && m_v[2] && m_v[3]);
      id_m = 2'd0;
      for (int i = 3; i >= 0; i--) if (!m_v[i]) id_m = 2'(i);
      cnt = 3'd0;
      for (int i = 0; i < 4; i++) cnt = cnt + {2'd0, m_v[i]};
      if (c != 0) begin
        e.rdy = rdy_m; e.id = id_m;
        e.h1 = model_haz(r_1, r_cv, r_cid);
        e.h2 = model_haz(r_2, r_cv, r_cid);
        e.hd = model_haz(r_d, r_cv, r_cid);
        e.out = cnt; e.busy = (cnt != 3'd0); e.err = m_err;
        sb_q.push_back(e);
      end
      @(negedge clk);
      if (c != 0) compare_outputs();
      @(posedge clk);
      if (r_rst) begin
        for (int i = 0; i < 4; i++) m_v[i] = 1'b0;
        m_err = 1'b0;
      end else if (r_fl) begin
        for (int i = 0; i < 4; i++) m_v[i] = 1'b0;
      end else begin
        if (r_cv) begin
          if (m_v[r_cid]) m_v[r_cid] = 1'b0;
          else m_err = 1'b1;
        end
        if (r_iv && rdy_m) begin
          m_v[id_m] = 1'b1; m_we[id_m] = r_we; m_wa[id_m] = r_wa;
        end
      end
      #1;
      drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
